// File: rtl/esm_dep_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | esm_pkg: shared types and instruction field positions for the      |
// | ESM dependency scheduler.                  Rev 1.0                  |
// +--------------------------------------------------------------------+
package esm_pkg;

    localparam int ESM_BS     = 16;
    localparam int ESM_REGNUM = 32;
    localparam int REG_W      = 5;

    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;

    typedef logic [$clog2(ESM_BS)-1:0] slot_idx_t;
    typedef logic [REG_W-1:0]          reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/esm_dep_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | esm_dep_scheduler_if: dispatch / issue / completion / retire bus.  |
// |                                            Rev 1.0                  |
// +--------------------------------------------------------------------+
interface esm_dep_scheduler_if #(
    parameter int INSTR_W    = 32,
    parameter int BS         = 16,
    parameter int DISPATCH_W = 2
);
    localparam int SLOT_W = $clog2(BS);
    localparam int RC_W   = $clog2(DISPATCH_W) + 1;

    logic [DISPATCH_W*INSTR_W-1:0] instr_in;
    logic [DISPATCH_W-1:0]         alu_src;
    logic [DISPATCH_W-1:0]         reg_write;
    logic [DISPATCH_W-1:0]         dispatch_valid;
    logic                          dispatch_ready;
    logic                          issue_valid;
    logic [SLOT_W-1:0]             issue_index;
    logic                          issue_ready;
    logic                          complete_valid;
    logic [SLOT_W-1:0]             complete_index;
    logic [RC_W-1:0]               retire_count;
    logic [BS-1:0]                 ready_positions;

    modport master (
        output instr_in, alu_src, reg_write, dispatch_valid,
        output issue_ready, complete_valid, complete_index,
        input  dispatch_ready, issue_valid, issue_index,
        input  retire_count, ready_positions
    );

    modport slave (
        input  instr_in, alu_src, reg_write, dispatch_valid,
        input  issue_ready, complete_valid, complete_index,
        output dispatch_ready, issue_valid, issue_index,
        output retire_count, ready_positions
    );

endinterface
`default_nettype wire

// File: rtl/esm_age_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | esm_age_picker: circular oldest-first select over N request bits   |
// | starting at i_head.                        Rev 1.0                  |
// +--------------------------------------------------------------------+
module esm_age_picker #(
    parameter int N = 16
) (
    input  wire logic [N-1:0]         i_req,
    input  wire logic [$clog2(N)-1:0] i_head,
    output logic                      o_valid,
    output logic [$clog2(N)-1:0]      o_idx
);
    localparam int IDX_W = $clog2(N);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;

    // w_rot[k] is the request k positions after head
    always_comb begin
        w_dbl = {i_req, i_req};
        w_rot = w_dbl[i_head +: N];
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IDX_W'(k);
        end
    end

    assign o_valid = |i_req;
    assign o_idx   = i_head + w_off;

endmodule
`default_nettype wire

// File: rtl/esm_dep_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | esm_dep_scheduler: multi-dispatch RAW dependency window with       |
// | oldest-first issue and in-order retire. Option: ESM_BYPASS_EN.     |
// |                                            Rev 1.0                  |
// +--------------------------------------------------------------------+
module esm_dep_scheduler
    import esm_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REGNUM     = 32,
    parameter int BS         = 16,
    parameter int DISPATCH_W = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    esm_dep_scheduler_if.slave  bus
);
    localparam int SLOT_W = $clog2(BS);
    localparam int CNT_W  = $clog2(BS) + 1;
    localparam int RC_W   = $clog2(DISPATCH_W) + 1;

    logic [BS-1:0]              valid_q, valid_d, issued_q, issued_d, done_q, done_d;
    logic [BS-1:0][BS-1:0]      dep_q, dep_d;
    logic [REGNUM-1:0]          lw_valid_q, lw_valid_d;
    logic [REGNUM-1:0][SLOT_W-1:0] lw_slot_q, lw_slot_d;
    logic [SLOT_W-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;

    reg_idx_t [DISPATCH_W-1:0]          w_rs1, w_rs2, w_rd;
    logic [DISPATCH_W-1:0][SLOT_W-1:0]  w_lane_slot;
    logic [DISPATCH_W-1:0][BS-1:0]      w_lane_dep;
    logic [BS-1:0]      w_cmpl_mask, w_byp_mask, w_ready;
    logic               w_cmpl_ok, w_pick_valid, w_issue_fire, w_disp_fire;
    logic               w_dispatch_ready, w_ret_stop;
    logic [SLOT_W-1:0]  w_pick_idx;
    logic [CNT_W-1:0]   w_disp_cnt;
    logic [RC_W-1:0]    w_ret_cnt;
    logic               w_unused_instr;

    assign w_unused_instr = ^bus.instr_in;

    for (genvar i = 0; i < DISPATCH_W; i++) begin : g_lane
        assign w_rs1[i]       = bus.instr_in[i*INSTR_W + RS1_LSB +: REG_W];
        assign w_rs2[i]       = bus.instr_in[i*INSTR_W + RS2_LSB +: REG_W];
        assign w_rd[i]        = bus.instr_in[i*INSTR_W + RD_LSB +: REG_W];
        assign w_lane_slot[i] = tail_q + SLOT_W'(i);
    end

    assign w_cmpl_ok = bus.complete_valid & valid_q[bus.complete_index]
                     & issued_q[bus.complete_index] & ~done_q[bus.complete_index];
    assign w_cmpl_mask = w_cmpl_ok ? ({{(BS-1){1'b0}}, 1'b1} << bus.complete_index) : '0;

`ifdef ESM_BYPASS_EN
    assign w_byp_mask = w_cmpl_mask;
`else
    assign w_byp_mask = '0;
`endif

    always_comb begin
        w_ready = '0;
        for (int s = 0; s < BS; s++) begin
            w_ready[s] = valid_q[s] & ~issued_q[s] & ~|(dep_q[s] & ~w_byp_mask);
        end
    end

    esm_age_picker #(.N(BS)) u_picker (
        .i_req   (w_ready),
        .i_head  (head_q),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_issue_fire     = w_pick_valid & bus.issue_ready;
    assign w_dispatch_ready = (CNT_W'(BS) - count_q) >= CNT_W'(DISPATCH_W);
    assign w_disp_fire      = w_dispatch_ready & |bus.dispatch_valid;

    // Retire counts the contiguous done run from head using registered state only
    always_comb begin
        w_ret_cnt  = '0;
        w_ret_stop = 1'b0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (!w_ret_stop && valid_q[head_q + SLOT_W'(k)] && done_q[head_q + SLOT_W'(k)])
                w_ret_cnt = w_ret_cnt + RC_W'(1);
            else
                w_ret_stop = 1'b1;
        end
        w_disp_cnt = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (w_disp_fire && bus.dispatch_valid[i]) w_disp_cnt = w_disp_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_lane_dep = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (w_rs1[i] != '0 && lw_valid_q[w_rs1[i]])
                w_lane_dep[i][lw_slot_q[w_rs1[i]]] = 1'b1;
            if (bus.alu_src[i] && w_rs2[i] != '0 && lw_valid_q[w_rs2[i]])
                w_lane_dep[i][lw_slot_q[w_rs2[i]]] = 1'b1;
            for (int j = 0; j < DISPATCH_W; j++) begin
                if (j < i && bus.dispatch_valid[j] && bus.reg_write[j] && w_rd[j] != '0 &&
                    (w_rd[j] == w_rs1[i] || (bus.alu_src[i] && w_rd[j] == w_rs2[i])))
                    w_lane_dep[i][w_lane_slot[j]] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d    = valid_q;
        issued_d   = issued_q;
        done_d     = done_q;
        dep_d      = dep_q;
        lw_valid_d = lw_valid_q;
        lw_slot_d  = lw_slot_q;
        head_d     = head_q + SLOT_W'(w_ret_cnt);
        tail_d     = tail_q + SLOT_W'(w_disp_cnt);
        count_d    = count_q + w_disp_cnt - CNT_W'(w_ret_cnt);

        if (w_issue_fire) issued_d[w_pick_idx] = 1'b1;

        if (w_cmpl_ok) begin
            done_d[bus.complete_index] = 1'b1;
            for (int r = 0; r < REGNUM; r++) begin
                if (lw_valid_q[r] && lw_slot_q[r] == bus.complete_index) lw_valid_d[r] = 1'b0;
            end
        end

        for (int k = 0; k < DISPATCH_W; k++) begin
            if (RC_W'(k) < w_ret_cnt) begin
                valid_d[head_q + SLOT_W'(k)]  = 1'b0;
                issued_d[head_q + SLOT_W'(k)] = 1'b0;
                done_d[head_q + SLOT_W'(k)]   = 1'b0;
                dep_d[head_q + SLOT_W'(k)]    = '0;
            end
        end

        // Lanes in order so the youngest writer of a register owns the table entry
        if (w_disp_fire) begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (bus.dispatch_valid[i]) begin
                    valid_d[w_lane_slot[i]]  = 1'b1;
                    issued_d[w_lane_slot[i]] = 1'b0;
                    done_d[w_lane_slot[i]]   = 1'b0;
                    dep_d[w_lane_slot[i]]    = w_lane_dep[i];
                    if (bus.reg_write[i] && w_rd[i] != '0) begin
                        lw_valid_d[w_rd[i]] = 1'b1;
                        lw_slot_d[w_rd[i]]  = w_lane_slot[i];
                    end
                end
            end
        end

        // Column clear also covers rows written this cycle, so no dependant is stranded
        for (int s = 0; s < BS; s++) begin
            dep_d[s] = dep_d[s] & ~w_cmpl_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            dep_q      <= '0;
            lw_valid_q <= '0;
            lw_slot_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            dep_q      <= dep_d;
            lw_valid_q <= lw_valid_d;
            lw_slot_q  <= lw_slot_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    assign bus.dispatch_ready  = w_dispatch_ready;
    assign bus.issue_valid     = w_pick_valid;
    assign bus.issue_index     = w_pick_idx;
    assign bus.retire_count    = w_ret_cnt;
    assign bus.ready_positions = w_ready;

endmodule
`default_nettype wire
